odd_even_combine: RTL and testbench

- Final stage of the Batcher odd-even merge. It is the counterpart of the odd/even splitter.
- Accepts the merged "odd" subsequence (original positions 0,2,4,…) and the merged "even" subsequence (positions 1,3,5,…), each n sorted lanes.
- Rebuilds one ascending 2n-lane sorted vector by interleaving and compare-exchanging adjacent pairs.
- Uses one shared comparator, sequenced by a small FSM. Valid/ready handshakes on both sides let it sit between merge-tree levels in the sorter pipeline.

---
 rtl/odd_even_combine.sv | 150 +++++++++++++++
 tb/tb_odd_even_combine.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/odd_even_combine.sv
`default_nettype none
// ============================================================================
// Module   : odd_even_combine
// Purpose  : Last stage of a Batcher odd-even merge. Interleaves a sorted
//            "odd" subsequence (original positions 0,2,4,...) with a sorted
//            "even" subsequence (positions 1,3,5,...) and then sweeps one
//            shared comparator over the adjacent pairs (1,2),(3,4),...,
//            (2n-3,2n-2). The result is a single ascending 2n-lane vector.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            in_valid/in_ready   - input handshake (ready only while idle)
//            inOdd, inEven       - n lanes each, lane k at [(k+1)*W-1:k*W]
//            out_valid/out_ready - output handshake
//            out                 - 2n lanes, lane 0 holds the smallest key
// Revision : 1.0 - initial release
// ============================================================================
module odd_even_combine #(
  parameter int WIDTH = 1,
  parameter int N     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*WIDTH-1:0]     inOdd,
  input  logic [N*WIDTH-1:0]     inEven,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*N*WIDTH-1:0]   out
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXCH = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [WIDTH-1:0]     c_q [2*N];
  logic [WIDTH-1:0]     c_d [2*N];
  logic [2*N*WIDTH-1:0] out_q, out_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;

  // Operands of the single shared comparator, steered by the pair index.
  logic [WIDTH-1:0]     lo_w, hi_w;
  logic                 swap_w;

  always_comb begin
    lo_w = '0;
    hi_w = '0;
    for (int k = 1; k < N; k++) begin
      if (idx_q == IW'(k)) begin
        lo_w = c_q[2*k-1];
        hi_w = c_q[2*k];
      end
    end
  end

  // Strictly greater: equal keys are never exchanged.
  assign swap_w = (lo_w > hi_w);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    c_d     = c_q;
    out_d   = out_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Interleave: odd lanes land on even positions, even lanes on odd.
          c_d[0]     = inOdd[0 +: WIDTH];
          for (int i = 1; i < N; i++) begin
            c_d[2*i-1] = inEven[(i-1)*WIDTH +: WIDTH];
            c_d[2*i]   = inOdd[i*WIDTH +: WIDTH];
          end
          c_d[2*N-1] = inEven[(N-1)*WIDTH +: WIDTH];
          idx_d      = IW'(1);
          state_d    = (N > 1) ? S_EXCH : S_DONE;
        end
      end

      S_EXCH: begin
        for (int k = 1; k < N; k++) begin
          if ((idx_q == IW'(k)) && swap_w) begin
            c_d[2*k-1] = hi_w;
            c_d[2*k]   = lo_w;
          end
        end
        if (idx_q == IW'(N-1)) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The output register only loads on entry to DONE, so it never shows a
    // partially exchanged vector and keeps the last result after acceptance.
    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      for (int k = 0; k < 2*N; k++) begin
        out_d[k*WIDTH +: WIDTH] = c_d[k];
      end
    end

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      out_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      for (int k = 0; k < 2*N; k++) begin
        c_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_q       <= out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      for (int k = 0; k < 2*N; k++) begin
        c_q[k] <= c_d[k];
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;

endmodule
`default_nettype wire

// File: tb/tb_odd_even_combine.sv
`default_nettype none
// ============================================================================
// Module   : tb_odd_even_combine
// Purpose  : Directed bench for odd_even_combine. One instance with WIDTH=4,
//            n=4 runs a table of merges; a second with WIDTH=8, n=1 covers
//            the degenerate single-pair case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_odd_even_combine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // n=4, WIDTH=4 instance
  logic        in_valid4, in_ready4, out_valid4, out_ready4;
  logic [15:0] odd4, even4;
  logic [31:0] out4;

  // n=1, WIDTH=8 instance
  logic        in_valid1, in_ready1, out_valid1, out_ready1;
  logic [7:0]  odd1, even1;
  logic [15:0] out1;

  odd_even_combine #(.WIDTH(4), .N(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .inOdd(odd4), .inEven(even4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out(out4)
  );

  odd_even_combine #(.WIDTH(8), .N(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .inOdd(odd1), .inEven(even1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out(out1)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [15:0] odd;
    logic [15:0] even;
    logic [31:0] expv;
    int          hold;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, expv);
    end
  endtask

  // One complete merge on the n=4 instance: capture, latency, result,
  // optional back-pressure window, acceptance and return to idle.
  task automatic run4(input vec_t v);
    int cyc;
    @(negedge clk);
    chk({v.name, " in_ready_before"}, {31'd0, in_ready4}, 32'd1);
    in_valid4 = 1'b1;
    odd4      = v.odd;
    even4     = v.even;
    @(posedge clk);
    #1 in_valid4 = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid4 && cyc < 20);
    chk({v.name, " latency"}, cyc, 32'd4);
    chk({v.name, " out"}, out4, v.expv);
    chk({v.name, " in_ready_busy"}, {31'd0, in_ready4}, 32'd0);
    for (int h = 0; h < v.hold; h++) begin
      // A request during back-pressure must be ignored.
      if (h == 1) begin
        in_valid4 = 1'b1;
        odd4      = 16'h0000;
        even4     = 16'h1111;
      end else begin
        in_valid4 = 1'b0;
      end
      @(negedge clk);
      chk({v.name, " hold_valid"}, {31'd0, out_valid4}, 32'd1);
      chk({v.name, " hold_out"}, out4, v.expv);
      chk({v.name, " hold_in_ready"}, {31'd0, in_ready4}, 32'd0);
    end
    in_valid4  = 1'b0;
    out_ready4 = 1'b1;
    @(posedge clk);
    #1 out_ready4 = 1'b0;
    @(negedge clk);
    chk({v.name, " in_ready_after"}, {31'd0, in_ready4}, 32'd1);
    chk({v.name, " out_valid_after"}, {31'd0, out_valid4}, 32'd0);
    chk({v.name, " out_kept"}, out4, v.expv);
  endtask

  task automatic run1(input logic [7:0] o, input logic [7:0] e, input logic [15:0] expv);
    int cyc;
    @(negedge clk);
    in_valid1 = 1'b1;
    odd1      = o;
    even1     = e;
    @(posedge clk);
    #1 in_valid1 = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid1 && cyc < 20);
    chk("n1 latency", cyc, 32'd1);
    chk("n1 out", {16'd0, out1}, {16'd0, expv});
    out_ready1 = 1'b1;
    @(posedge clk);
    #1 out_ready1 = 1'b0;
    @(negedge clk);
    chk("n1 in_ready_after", {31'd0, in_ready1}, 32'd1);
    chk("n1 out_valid_after", {31'd0, out_valid1}, 32'd0);
  endtask

  initial begin
    int cyc;
    // name, odd lanes 3..0, even lanes 3..0, expected out lanes 7..0, hold
    vecs[0] = '{"basic",     16'h7621, 16'h9843, 32'h98764321, 0};
    vecs[1] = '{"backpress", 16'h7621, 16'h9843, 32'h98764321, 5};
    vecs[2] = '{"ties_max",  16'hFFF0, 16'hFFFF, 32'hFFFFFFF0, 0};
    vecs[3] = '{"all_five",  16'h5555, 16'h5555, 32'h55555555, 0};
    vecs[4] = '{"swap_all",  16'h3210, 16'h7654, 32'h76352410, 0};
    vecs[5] = '{"no_swap",   16'hC952, 16'hEA73, 32'hECA97532, 0};
    vecs[6] = '{"zero_one",  16'h0000, 16'h1111, 32'h11010100, 0};

    in_valid4 = 1'b0; out_ready4 = 1'b0; odd4 = '0; even4 = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; odd1 = '0; even1 = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset in_ready", {31'd0, in_ready4}, 32'd1);
    chk("reset out_valid", {31'd0, out_valid4}, 32'd0);
    chk("reset out", out4, 32'd0);
    chk("reset n1 in_ready", {31'd0, in_ready1}, 32'd1);
    chk("reset n1 out", {16'd0, out1}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      run4(vecs[i]);
    end

    // Reset during the second exchange cycle drops the merge in flight.
    @(negedge clk);
    in_valid4 = 1'b1;
    odd4      = 16'h3210;
    even4     = 16'h7654;
    @(posedge clk);
    #1 in_valid4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst in_ready", {31'd0, in_ready4}, 32'd1);
    chk("midrst out_valid", {31'd0, out_valid4}, 32'd0);
    chk("midrst out", out4, 32'd0);
    cyc = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid4) cyc++;
    end
    chk("midrst stays idle", cyc, 32'd0);
    run4(vecs[0]);

    // Single-pair instance: direct IDLE -> DONE, no exchange.
    run1(8'h3C, 8'hA5, 16'hA53C);
    run1(8'hA5, 8'h3C, 16'h3CA5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
